// File: rtl/pipe_cpu_fwd.sv
// Four-stage (IF/ID/EX/WB) 16-bit-instruction CPU with full operand forwarding in ID.
// Never stalls on data hazards; HALT drains the pipeline and freezes fetch.
module pipe_cpu_fwd #(
  parameter int unsigned DW       = 8,
  parameter int unsigned IM_DEPTH = 16,
  parameter int unsigned DM_DEPTH = 16,
  localparam int unsigned AW      = $clog2(IM_DEPTH),
  localparam int unsigned DAW     = $clog2(DM_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [15:0]   prog_data,
  input  logic [3:0]    dbg_addr,
  output logic [DW-1:0] dbg_data,
  output logic [AW-1:0] pc,
  output logic          retire,
  output logic          halted
);

  typedef enum logic [3:0] {
    OpAdd   = 4'h0,
    OpSub   = 4'h1,
    OpLoad  = 4'h2,
    OpStore = 4'h3,
    OpLdi   = 4'h4,
    OpAnd   = 4'h5,
    OpOr    = 4'h6,
    OpXor   = 4'h7,
    OpHalt  = 4'hF
  } op_e;

  function automatic logic writes_rd(input logic [3:0] op);
    return op inside {OpAdd, OpSub, OpLoad, OpLdi, OpAnd, OpOr, OpXor};
  endfunction

  logic [15:0]   imem [IM_DEPTH];
  logic [DW-1:0] dmem [DM_DEPTH];
  logic [DW-1:0] rf   [16];

  logic [AW-1:0] pc_q;
  logic          halted_q;

  logic          ifid_valid;
  logic [15:0]   ifid_instr;

  logic          idex_valid;
  logic [3:0]    idex_op;
  logic [3:0]    idex_rd;
  logic [DW-1:0] idex_a;
  logic [DW-1:0] idex_b;
  logic [DW-1:0] idex_imm;

  logic          exwb_valid;
  logic          exwb_we;
  logic          exwb_halt;
  logic [3:0]    exwb_rd;
  logic [DW-1:0] exwb_res;

  // ID decode
  logic [3:0]    id_op, id_rd, id_rs1, id_rs2;
  logic [DW-1:0] id_a, id_b;
  logic          id_halt;

  assign id_op   = ifid_instr[15:12];
  assign id_rd   = ifid_instr[11:8];
  assign id_rs1  = ifid_instr[7:4];
  assign id_rs2  = ifid_instr[3:0];
  assign id_halt = ifid_valid && (id_op == OpHalt);

  // EX
  logic [DW-1:0] ex_res;
  logic          ex_we, ex_halt, ex_store;

  assign ex_we    = idex_valid && writes_rd(idex_op);
  assign ex_halt  = idex_valid && (idex_op == OpHalt);
  assign ex_store = idex_valid && (idex_op == OpStore);

  always_comb begin
    ex_res = '0;
    case (idex_op)
      OpAdd:   ex_res = idex_a + idex_b;
      OpSub:   ex_res = idex_a - idex_b;
      OpLoad:  ex_res = dmem[idex_a[DAW-1:0]];
      OpLdi:   ex_res = idex_imm;
      OpAnd:   ex_res = idex_a & idex_b;
      OpOr:    ex_res = idex_a | idex_b;
      OpXor:   ex_res = idex_a ^ idex_b;
      default: ex_res = '0;
    endcase
  end

  // Later assignments win: EX result overrides WB result overrides the register file.
  always_comb begin
    id_a = rf[id_rs1];
    id_b = rf[id_rs2];
    if (exwb_valid && exwb_we && exwb_rd == id_rs1) id_a = exwb_res;
    if (exwb_valid && exwb_we && exwb_rd == id_rs2) id_b = exwb_res;
    if (ex_we && idex_rd == id_rs1) id_a = ex_res;
    if (ex_we && idex_rd == id_rs2) id_b = ex_res;
  end

  // Fetch stays stopped from HALT reaching ID until reset.
  logic fetch_stop;
  assign fetch_stop = halted_q || id_halt || ex_halt || (exwb_valid && exwb_halt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= '0;
      halted_q   <= 1'b0;
      ifid_valid <= 1'b0;
      ifid_instr <= '0;
      idex_valid <= 1'b0;
      idex_op    <= '0;
      idex_rd    <= '0;
      idex_a     <= '0;
      idex_b     <= '0;
      idex_imm   <= '0;
      exwb_valid <= 1'b0;
      exwb_we    <= 1'b0;
      exwb_halt  <= 1'b0;
      exwb_rd    <= '0;
      exwb_res   <= '0;
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else if (run) begin
      if (fetch_stop) begin
        ifid_valid <= 1'b0;
      end else begin
        pc_q       <= pc_q + AW'(1);
        ifid_valid <= 1'b1;
        ifid_instr <= imem[pc_q];
      end

      idex_valid <= ifid_valid;
      idex_op    <= id_op;
      idex_rd    <= id_rd;
      idex_a     <= id_a;
      idex_b     <= id_b;
      idex_imm   <= DW'(ifid_instr[7:0]);

      exwb_valid <= idex_valid;
      exwb_we    <= ex_we;
      exwb_halt  <= ex_halt;
      exwb_rd    <= idex_rd;
      exwb_res   <= ex_res;

      if (ex_halt) halted_q <= 1'b1;
      if (exwb_valid && exwb_we) rf[exwb_rd] <= exwb_res;
    end
  end

  // Memories are deliberately not reset.
  always_ff @(posedge clk) begin
    if (!run && prog_we) imem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (run && ex_store) dmem[idex_a[DAW-1:0]] <= idex_b;
  end

  assign dbg_data = rf[dbg_addr];
  assign pc       = pc_q;
  assign retire   = run && exwb_valid;
  assign halted   = halted_q;

endmodule

// File: tb/tb_pipe_cpu_fwd.sv
// Directed bench for pipe_cpu_fwd: forwarding, load-use, HALT, freeze and async reset.
// A DW=16 instance runs alongside the DW=8 one to check width-dependent wrap.
module tb_pipe_cpu_fwd;

  logic        clk = 1'b0;
  logic        reset, run, prog_we;
  logic [3:0]  prog_addr;
  logic [15:0] prog_data;
  logic [3:0]  dbg_addr;
  logic [7:0]  dbg_data;
  logic [3:0]  pc;
  logic        retire, halted;
  logic [15:0] dbg_data16;
  logic [3:0]  pc16;
  logic        retire16, halted16;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [15:0] prog [16];

  always #5 clk = ~clk;

  pipe_cpu_fwd #(.DW(8), .IM_DEPTH(16), .DM_DEPTH(16)) u_dut (
    .clk(clk), .reset(reset), .run(run), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .pc(pc),
    .retire(retire), .halted(halted)
  );

  pipe_cpu_fwd #(.DW(16), .IM_DEPTH(16), .DM_DEPTH(16)) u_dut16 (
    .clk(clk), .reset(reset), .run(run), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data16), .pc(pc16),
    .retire(retire16), .halted(halted16)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) prog[i] = 16'hF000;
  endtask

  // Hold reset, load prog[] into imem, release reset; caller raises run for cycle 1.
  task automatic do_reset();
    run     = 1'b0;
    prog_we = 1'b0;
    reset   = 1'b1;
    step();
    for (int i = 0; i < 16; i++) begin
      prog_addr = i[3:0];
      prog_data = prog[i];
      prog_we   = 1'b1;
      step();
    end
    prog_we = 1'b0;
    reset   = 1'b0;
    step();
  endtask

  task automatic rd_reg(input int idx, output logic [7:0] v8, output logic [15:0] v16);
    dbg_addr = idx[3:0];
    #1;
    v8  = dbg_data;
    v16 = dbg_data16;
  endtask

  task automatic test_reset();
    logic [7:0]  v8;
    logic [15:0] v16;
    clear_prog();
    do_reset();
    total_cnt++;
    if (pc !== 4'd0) $display("FAIL reset_pc: got %0h want 0", pc); else pass_cnt++;
    total_cnt++;
    if (halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", halted); else pass_cnt++;
    total_cnt++;
    if (retire !== 1'b0) $display("FAIL reset_retire: got %b want 0", retire); else pass_cnt++;
    for (int r = 0; r < 16; r++) begin
      rd_reg(r, v8, v16);
      total_cnt++;
      if (v8 !== 8'h00) $display("FAIL reset_r%0d: got %h want 00", r, v8); else pass_cnt++;
    end
  endtask

  task automatic test_fwd_add();
    logic [7:0]  v8;
    logic [15:0] v16;
    logic        exp_ret [1:6];
    exp_ret = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    clear_prog();
    prog[0] = 16'h4105;  // LDI r1,5
    prog[1] = 16'h4203;  // LDI r2,3
    prog[2] = 16'h0312;  // ADD r3,r1,r2
    do_reset();
    run = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      total_cnt++;
      if (retire !== exp_ret[c])
        $display("FAIL fwd_retire_cycle%0d: got %b want %b", c, retire, exp_ret[c]);
      else pass_cnt++;
      step();
    end
    repeat (4) step();
    run = 1'b0;
    rd_reg(3, v8, v16);
    total_cnt++;
    if (v8 !== 8'h08) $display("FAIL fwd_r3: got %h want 08", v8); else pass_cnt++;
    rd_reg(1, v8, v16);
    total_cnt++;
    if (v8 !== 8'h05) $display("FAIL fwd_r1: got %h want 05", v8); else pass_cnt++;
    rd_reg(2, v8, v16);
    total_cnt++;
    if (v8 !== 8'h03) $display("FAIL fwd_r2: got %h want 03", v8); else pass_cnt++;
  endtask

  task automatic test_sub_wrap();
    logic [7:0]  v8;
    logic [15:0] v16;
    clear_prog();
    prog[0] = 16'h4103;  // LDI r1,3
    prog[1] = 16'h4205;  // LDI r2,5
    prog[2] = 16'h1312;  // SUB r3,r1,r2
    do_reset();
    run = 1'b1;
    repeat (8) step();
    run = 1'b0;
    rd_reg(3, v8, v16);
    total_cnt++;
    if (v8 !== 8'hFE) $display("FAIL sub_r3_dw8: got %h want fe", v8); else pass_cnt++;
    total_cnt++;
    if (v16 !== 16'hFFFE) $display("FAIL sub_r3_dw16: got %h want fffe", v16); else pass_cnt++;
  endtask

  task automatic test_load_store();
    logic [7:0]  v8;
    logic [15:0] v16;
    clear_prog();
    prog[0] = 16'h4112;  // LDI r1,0x12
    prog[1] = 16'h427A;  // LDI r2,0x7A
    prog[2] = 16'h3012;  // STORE dmem[r1]=r2 -> dmem[2]
    prog[3] = 16'h2410;  // LOAD r4,r1
    prog[4] = 16'h0544;  // ADD r5,r4,r4 (load-use)
    prog[5] = 16'h4722;  // LDI r7,0x22
    prog[6] = 16'h2670;  // LOAD r6,r7 -> wraps to dmem[2]
    do_reset();
    run = 1'b1;
    repeat (14) step();
    run = 1'b0;
    rd_reg(4, v8, v16);
    total_cnt++;
    if (v8 !== 8'h7A) $display("FAIL ls_r4: got %h want 7a", v8); else pass_cnt++;
    rd_reg(5, v8, v16);
    total_cnt++;
    if (v8 !== 8'hF4) $display("FAIL ls_r5: got %h want f4", v8); else pass_cnt++;
    rd_reg(6, v8, v16);
    total_cnt++;
    if (v8 !== 8'h7A) $display("FAIL ls_wrap_r6: got %h want 7a", v8); else pass_cnt++;
    total_cnt++;
    if (v16 !== 16'h007A) $display("FAIL ls_wrap_r6_dw16: got %h want 007a", v16);
    else pass_cnt++;
  endtask

  task automatic test_halt();
    logic [7:0]  v8;
    logic [15:0] v16;
    int          cnt;
    clear_prog();
    prog[0] = 16'h4101;  // LDI r1,1
    prog[1] = 16'hF000;  // HALT
    prog[2] = 16'h4109;  // LDI r1,9
    prog[3] = 16'h4109;
    do_reset();
    run = 1'b1;
    cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      if (retire) cnt++;
      if (c == 4) begin
        total_cnt++;
        if (halted !== 1'b0) $display("FAIL halt_early: got %b want 0", halted); else pass_cnt++;
      end
      if (c == 5) begin
        total_cnt++;
        if ({halted, retire} !== 2'b11)
          $display("FAIL halt_enter_wb: got %b want 11", {halted, retire});
        else pass_cnt++;
      end
      step();
    end
    run = 1'b0;
    total_cnt++;
    if (cnt !== 2) $display("FAIL halt_retires: got %0d want 2", cnt); else pass_cnt++;
    total_cnt++;
    if (pc !== 4'd2) $display("FAIL halt_pc: got %0h want 2", pc); else pass_cnt++;
    total_cnt++;
    if (halted !== 1'b1) $display("FAIL halt_sticky: got %b want 1", halted); else pass_cnt++;
    rd_reg(1, v8, v16);
    total_cnt++;
    if (v8 !== 8'h01) $display("FAIL halt_r1: got %h want 01", v8); else pass_cnt++;
  endtask

  task automatic test_freeze();
    logic [7:0]  v8;
    logic [15:0] v16;
    int          cnt;
    clear_prog();
    prog[0] = 16'h4105;
    prog[1] = 16'h4203;
    prog[2] = 16'h0312;
    do_reset();
    run = 1'b1;
    step();
    step();
    run = 1'b0;
    for (int f = 0; f < 3; f++) begin
      total_cnt++;
      if (retire !== 1'b0) $display("FAIL frz_retire%0d: got %b want 0", f, retire);
      else pass_cnt++;
      total_cnt++;
      if (pc !== 4'd2) $display("FAIL frz_pc%0d: got %0h want 2", f, pc); else pass_cnt++;
      // Patch addr 3 (not yet fetched) with LDI r9,0x5A while frozen.
      prog_we   = (f == 0);
      prog_addr = 4'd3;
      prog_data = 16'h495A;
      step();
      prog_we = 1'b0;
    end
    run = 1'b1;
    // Write while running must be ignored: addr 4 stays HALT.
    prog_we   = 1'b1;
    prog_addr = 4'd4;
    prog_data = 16'h4A11;
    cnt = 0;
    for (int c = 0; c < 14; c++) begin
      if (retire) cnt++;
      step();
      prog_we = 1'b0;
    end
    run = 1'b0;
    // LDI, LDI, ADD, patched LDI r9, HALT
    total_cnt++;
    if (cnt !== 5) $display("FAIL frz_retires: got %0d want 5", cnt); else pass_cnt++;
    rd_reg(3, v8, v16);
    total_cnt++;
    if (v8 !== 8'h08) $display("FAIL frz_r3: got %h want 08", v8); else pass_cnt++;
    rd_reg(9, v8, v16);
    total_cnt++;
    if (v8 !== 8'h5A) $display("FAIL frz_prog_r9: got %h want 5a", v8); else pass_cnt++;
    rd_reg(10, v8, v16);
    total_cnt++;
    if (v8 !== 8'h00) $display("FAIL run_prog_ignored_r10: got %h want 00", v8); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [7:0]  v8;
    logic [15:0] v16;
    clear_prog();
    prog[0] = 16'h4101;
    prog[1] = 16'hF000;
    do_reset();
    run = 1'b1;
    repeat (4) step();
    total_cnt++;
    if ({halted, retire} !== 2'b11)
      $display("FAIL rstmid_pre: got %b want 11", {halted, retire});
    else pass_cnt++;
    #2;
    reset = 1'b1;
    #1;
    total_cnt++;
    if (pc !== 4'd0) $display("FAIL rstmid_pc: got %0h want 0", pc); else pass_cnt++;
    total_cnt++;
    if (halted !== 1'b0) $display("FAIL rstmid_halted: got %b want 0", halted); else pass_cnt++;
    total_cnt++;
    if (retire !== 1'b0) $display("FAIL rstmid_retire: got %b want 0", retire); else pass_cnt++;
    for (int r = 0; r < 16; r++) begin
      rd_reg(r, v8, v16);
      total_cnt++;
      if (v8 !== 8'h00) $display("FAIL rstmid_r%0d: got %h want 00", r, v8); else pass_cnt++;
    end
    run   = 1'b0;
    reset = 1'b0;
    step();
  endtask

  initial begin
    reset     = 1'b1;
    run       = 1'b0;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    dbg_addr  = '0;
    test_reset();
    test_fwd_add();
    test_sub_wrap();
    test_load_store();
    test_halt();
    test_freeze();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
